adder_station: RTL and testbench

//  Reservation station plus integer adder: the consumer end of the reorder buffer's issue bus and the producer for one

---
 rtl/adder_station_pkg.sv | 50 +++++
 rtl/adder_station_rs_operand_slot.sv | 82 ++++++++
 rtl/adder_station.sv | 146 ++++++++++++++
 tb/tb_adder_station.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_station_pkg.sv
// +--------------------------------------------------------------------------+
// | adder_station_pkg: opcodes, tag encodings, field positions, FSM states    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package adder_station_pkg;

  localparam logic [3:0] INST_ADD  = 4'h1;
  localparam logic [3:0] INST_SUB  = 4'h2;
  localparam logic [3:0] INST_ADDI = 4'h3;
  localparam logic [3:0] INST_SUBI = 4'h4;

  // Tag value meaning "operand already current"; all-ones at any tag width.
  localparam logic [7:0] READY_TAG = 8'hFF;
  localparam logic [3:0] NO_FU     = 4'hF;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 23;
  localparam int RS_MSB  = 22;
  localparam int RS_LSB  = 18;
  localparam int RT_MSB  = 17;
  localparam int RT_LSB  = 13;
  localparam int IMM_MSB = 12;
  localparam int IMM_W   = 13;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_OPS = 2'd1,
    S_EXEC     = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == INST_ADD) || (op == INST_SUB) || (op == INST_ADDI) || (op == INST_SUBI);
  endfunction

  function automatic logic is_imm_op(input logic [3:0] op);
    return (op == INST_ADDI) || (op == INST_SUBI);
  endfunction

  function automatic logic is_sub_op(input logic [3:0] op);
    return (op == INST_SUB) || (op == INST_SUBI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_station_rs_operand_slot.sv
// +--------------------------------------------------------------------------+
// | rs_operand_slot: one source operand of the station; captures it at issue  |
// | or later by snooping the result bus for its producer tag. Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module rs_operand_slot
  import adder_station_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         use_imm,
  input  logic [WORD_SIZE-1:0]         imm_val,
  input  logic [WORD_SIZE-1:0]         v_in,
  input  logic [RB_INDEX-1:0]          q_in,
  input  logic [RB_SIZE*WORD_SIZE-1:0] cdb_data,
  input  logic [RB_SIZE-1:0]           cdb_valid,
  output logic                         ready,
  output logic                         ready_next,
  output logic [WORD_SIZE-1:0]         value
);

  localparam logic [RB_INDEX-1:0] READY = READY_TAG[RB_INDEX-1:0];

  logic [WORD_SIZE-1:0] bus_word [RB_SIZE];
  logic [WORD_SIZE-1:0] value_q, value_d;
  logic [RB_INDEX-1:0]  tag_q, tag_d;
  logic                 pending_q, pending_d;

  generate
    for (genvar i = 0; i < RB_SIZE; i++) begin : g_unpack
      assign bus_word[i] = cdb_data[i*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  always_comb begin
    value_d   = value_q;
    tag_d     = tag_q;
    pending_d = pending_q;
    if (load) begin
      tag_d     = q_in;
      pending_d = 1'b0;
      if (use_imm) begin
        value_d = imm_val;
        tag_d   = READY;
      end else if (q_in == READY) begin
        value_d = v_in;
      end else if (cdb_valid[q_in]) begin
        value_d = bus_word[q_in];
      end else begin
        pending_d = 1'b1;
      end
    end else if (pending_q && cdb_valid[tag_q]) begin
      value_d   = bus_word[tag_q];
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= '0;
      tag_q     <= READY;
      pending_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      tag_q     <= tag_d;
      pending_q <= pending_d;
    end
  end

  assign ready      = ~pending_q;
  assign ready_next = ~pending_d;
  assign value      = value_q;

endmodule

`default_nettype wire

// File: rtl/adder_station.sv
// +--------------------------------------------------------------------------+
// | adder_station: reservation station + integer add/sub unit returning one   |
// | result onto its reorder-buffer slot of the result bus. Rev 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module adder_station
  import adder_station_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int REG_INDEX = 5,
  parameter int FU_INDEX  = 4,
  parameter int FU_ID     = 0,
  parameter int ADD_LAT   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [FU_INDEX-1:0]          CDB_inst_fu,
  input  logic [WORD_SIZE-1:0]         CDB_inst_inst,
  input  logic [RB_INDEX-1:0]          CDB_inst_RBindex,
  output logic                         busy,
  output logic [REG_INDEX-1:0]         numj,
  output logic [REG_INDEX-1:0]         numk,
  input  logic [WORD_SIZE-1:0]         vj,
  input  logic [WORD_SIZE-1:0]         vk,
  input  logic [RB_INDEX-1:0]          qj,
  input  logic [RB_INDEX-1:0]          qk,
  input  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data,
  input  logic [RB_SIZE-1:0]           CDB_data_valid,
  output logic [RB_SIZE*WORD_SIZE-1:0] res_data,
  output logic [RB_SIZE*WORD_SIZE-1:0] res_addr,
  output logic [RB_SIZE-1:0]           res_valid
);

  localparam int CNT_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

  // Flush is the ROB's short kill pulse, so it joins reset as an async clear.
  logic clr_n;
  assign clr_n = reset & ~flush;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [RB_INDEX-1:0]  rbidx_q, rbidx_d;
  logic [WORD_SIZE-1:0] result_q, result_d;

  logic [3:0]           inst_op;
  logic [WORD_SIZE-1:0] imm_sext;
  logic                 issue;
  logic                 j_ready, j_ready_next, k_ready, k_ready_next;
  logic [WORD_SIZE-1:0] j_val, k_val;
  logic                 unused_rd;

  assign inst_op   = CDB_inst_inst[OP_MSB:OP_LSB];
  assign imm_sext  = {{(WORD_SIZE-IMM_W){CDB_inst_inst[IMM_MSB]}}, CDB_inst_inst[IMM_MSB:0]};
  assign numj      = CDB_inst_inst[RS_MSB:RS_LSB];
  assign numk      = CDB_inst_inst[RT_MSB:RT_LSB];
  assign unused_rd = ^CDB_inst_inst[RD_MSB:RD_LSB];

  assign issue = (state_q == S_IDLE) && (CDB_inst_fu == FU_INDEX'(FU_ID)) && is_arith_op(inst_op);

  rs_operand_slot #(
    .WORD_SIZE(WORD_SIZE), .RB_SIZE(RB_SIZE), .RB_INDEX(RB_INDEX)
  ) u_slot_j (
    .clk(clk), .rst_n(clr_n), .load(issue), .use_imm(1'b0), .imm_val('0),
    .v_in(vj), .q_in(qj), .cdb_data(CDB_data_data), .cdb_valid(CDB_data_valid),
    .ready(j_ready), .ready_next(j_ready_next), .value(j_val)
  );

  rs_operand_slot #(
    .WORD_SIZE(WORD_SIZE), .RB_SIZE(RB_SIZE), .RB_INDEX(RB_INDEX)
  ) u_slot_k (
    .clk(clk), .rst_n(clr_n), .load(issue), .use_imm(is_imm_op(inst_op)), .imm_val(imm_sext),
    .v_in(vk), .q_in(qk), .cdb_data(CDB_data_data), .cdb_valid(CDB_data_valid),
    .ready(k_ready), .ready_next(k_ready_next), .value(k_val)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rbidx_d  = rbidx_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          op_d    = inst_op;
          rbidx_d = CDB_inst_RBindex;
          cnt_d   = CNT_W'(ADD_LAT);
          state_d = (j_ready_next && k_ready_next) ? S_EXEC : S_WAIT_OPS;
        end
      end
      S_WAIT_OPS: begin
        if (j_ready_next && k_ready_next) begin
          cnt_d   = CNT_W'(ADD_LAT);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          result_d = is_sub_op(op_q) ? (j_val - k_val) : (j_val + k_val);
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        result_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rbidx_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rbidx_q  <= rbidx_d;
      result_q <= result_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign res_addr = '0;

  generate
    for (genvar i = 0; i < RB_SIZE; i++) begin : g_res_slot
      assign res_valid[i] = (state_q == S_DONE) && (rbidx_q == RB_INDEX'(i));
      assign res_data[i*WORD_SIZE +: WORD_SIZE] = res_valid[i] ? result_q : '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_adder_station.sv
// +--------------------------------------------------------------------------+
// | tb_adder_station: directed vector table plus multi-cycle sequences for    |
// | adder_station. Rev 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_adder_station;
  import adder_station_pkg::*;

  localparam int W   = 32;
  localparam int RBS = 8;
  localparam int LAT = 2;
  localparam logic [2:0] RDY = 3'b111;

  logic            clk = 1'b0;
  logic            reset, flush;
  logic [3:0]      CDB_inst_fu;
  logic [W-1:0]    CDB_inst_inst;
  logic [2:0]      CDB_inst_RBindex;
  logic            busy;
  logic [4:0]      numj, numk;
  logic [W-1:0]    vj, vk;
  logic [2:0]      qj, qk;
  logic [RBS*W-1:0] CDB_data_data;
  logic [RBS-1:0]  CDB_data_valid;
  logic [RBS*W-1:0] res_data, res_addr;
  logic [RBS-1:0]  res_valid;

  adder_station #(
    .WORD_SIZE(W), .RB_SIZE(RBS), .RB_INDEX(3), .REG_INDEX(5),
    .FU_INDEX(4), .FU_ID(0), .ADD_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .CDB_inst_fu(CDB_inst_fu), .CDB_inst_inst(CDB_inst_inst), .CDB_inst_RBindex(CDB_inst_RBindex),
    .busy(busy), .numj(numj), .numk(numk), .vj(vj), .vk(vk), .qj(qj), .qk(qk),
    .CDB_data_data(CDB_data_data), .CDB_data_valid(CDB_data_valid),
    .res_data(res_data), .res_addr(res_addr), .res_valid(res_valid)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [12:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  qa;
    logic [2:0]  qb;
    logic [2:0]  rb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];
  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [12:0] imm);
    return {op, 5'd3, rs, rt, imm};
  endfunction

  // Called just after a negedge; returns at the negedge following the accepting posedge.
  task automatic do_issue(input string name, input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [12:0] imm, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] qa, input logic [2:0] qb, input logic [2:0] rb);
    CDB_inst_fu      = 4'd0;
    CDB_inst_inst    = mk(op, rs, rt, imm);
    CDB_inst_RBindex = rb;
    vj = a; vk = b; qj = qa; qk = qb;
    #1;
    check({name, "_numj"}, 256'(numj), 256'(rs));
    check({name, "_numk"}, 256'(numk), 256'(rt));
    @(posedge clk);
    @(negedge clk);
    CDB_inst_fu = NO_FU;
  endtask

  task automatic wait_result(input string name, input logic [2:0] rb, input logic [31:0] data, input int lat);
    int n;
    logic [255:0] exp_data;
    n = 0;
    while (res_valid == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp_data = '0;
    exp_data[rb*32 +: 32] = data;
    check({name, "_latency"}, 256'(n), 256'(lat));
    check({name, "_valid"}, 256'(res_valid), 256'(8'd1 << rb));
    check({name, "_data"}, res_data, exp_data);
    check({name, "_addr"}, res_addr, '0);
    check({name, "_busy_done"}, 256'(busy), 256'(1'b1));
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    check({name, "_idle_busy"}, 256'(busy), 256'(1'b0));
    check({name, "_idle_valid"}, 256'(res_valid), 256'(0));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic seen;
    vecs[0] = '{INST_ADD,  13'h0000, 32'd5,          32'd7, RDY, RDY,  3'd2, 32'd12};
    vecs[1] = '{INST_SUB,  13'h0000, 32'd3,          32'd5, RDY, RDY,  3'd0, 32'hFFFF_FFFE};
    vecs[2] = '{INST_ADDI, 13'h0005, 32'hFFFF_FFFF,  32'd0, RDY, 3'd3, 3'd7, 32'd4};
    vecs[3] = '{INST_SUBI, 13'h1FFF, 32'd10,         32'd0, RDY, RDY,  3'd1, 32'd11};
    vecs[4] = '{INST_SUB,  13'h0000, 32'h8000_0000,  32'd1, RDY, RDY,  3'd6, 32'h7FFF_FFFF};
    vecs[5] = '{INST_ADDI, 13'h1000, 32'd100,        32'd0, RDY, RDY,  3'd5, 32'hFFFF_F064};

    reset = 1'b0; flush = 1'b0;
    CDB_inst_fu = NO_FU; CDB_inst_inst = '0; CDB_inst_RBindex = '0;
    vj = '0; vk = '0; qj = RDY; qk = RDY;
    CDB_data_data = '0; CDB_data_valid = '0;

    #5;
    check("reset_busy", 256'(busy), 256'(1'b0));
    check("reset_valid", 256'(res_valid), 256'(0));
    check("reset_data", res_data, '0);
    check("reset_addr", res_addr, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Unknown opcode to this FU and a valid op to another FU are both ignored.
    CDB_inst_fu = 4'd0; CDB_inst_inst = mk(4'hF, 5'd1, 5'd2, 13'd0);
    @(posedge clk); @(negedge clk);
    check("bad_op_ignored", 256'(busy), 256'(1'b0));
    CDB_inst_fu = 4'd1; CDB_inst_inst = mk(INST_ADD, 5'd1, 5'd2, 13'd0);
    @(posedge clk); @(negedge clk);
    check("other_fu_ignored", 256'(busy), 256'(1'b0));
    CDB_inst_fu = NO_FU;

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      do_issue(nm, vecs[i].op, 5'(i + 1), 5'(i + 9), vecs[i].imm, vecs[i].a, vecs[i].b,
               vecs[i].qa, vecs[i].qb, vecs[i].rb);
      check({nm, "_busy_issue"}, 256'(busy), 256'(1'b1));
      wait_result(nm, vecs[i].rb, vecs[i].exp, LAT);
      expect_idle(nm);
    end

    // j pending on tag 4; an unrelated slot goes valid first and must not be taken.
    do_issue("pend", INST_ADD, 5'd4, 5'd5, 13'd0, 32'd0, 32'd1, 3'd4, RDY, 3'd6);
    CDB_data_valid[3] = 1'b1; CDB_data_data[3*32 +: 32] = 32'd77;
    @(negedge clk);
    CDB_data_valid = '0;
    @(negedge clk);
    check("pend_wait_busy", 256'(busy), 256'(1'b1));
    check("pend_wait_valid", 256'(res_valid), 256'(0));
    @(negedge clk);
    CDB_data_valid[4] = 1'b1; CDB_data_data[4*32 +: 32] = 32'd41;
    @(negedge clk);
    CDB_data_valid = '0;
    wait_result("pend", 3'd6, 32'd42, LAT);
    expect_idle("pend");

    // Both operands wait on the same tag and must capture on one edge.
    do_issue("same_tag", INST_ADD, 5'd6, 5'd7, 13'd0, 32'd0, 32'd0, 3'd5, 3'd5, 3'd1);
    CDB_data_valid[5] = 1'b1; CDB_data_data[5*32 +: 32] = 32'h8000_0000;
    @(negedge clk);
    CDB_data_valid = '0;
    wait_result("same_tag", 3'd1, 32'd0, LAT);
    expect_idle("same_tag");

    // Short flush pulse while waiting kills the instruction.
    do_issue("flush", INST_ADD, 5'd8, 5'd9, 13'd0, 32'd0, 32'd2, 3'd5, RDY, 3'd3);
    check("flush_busy_before", 256'(busy), 256'(1'b1));
    #3 flush = 1'b1;
    #1 check("flush_immediate", 256'(busy), 256'(1'b0));
    #1 flush = 1'b0;
    @(negedge clk);
    CDB_data_valid[5] = 1'b1; CDB_data_data[5*32 +: 32] = 32'd7;
    @(negedge clk);
    CDB_data_valid = '0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (res_valid != '0) seen = 1'b1;
    end
    check("flush_no_result", 256'(seen), 256'(1'b0));
    check("flush_busy_after", 256'(busy), 256'(1'b0));

    // Asynchronous reset mid-execution, then a fresh instruction.
    do_issue("rst_mid", INST_ADD, 5'd1, 5'd2, 13'd0, 32'd5, 32'd6, RDY, RDY, 3'd3);
    check("rst_mid_busy_exec", 256'(busy), 256'(1'b1));
    #3 reset = 1'b0;
    #1;
    check("rst_mid_busy", 256'(busy), 256'(1'b0));
    check("rst_mid_valid", 256'(res_valid), 256'(0));
    check("rst_mid_data", res_data, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_issue("after_rst", INST_ADD, 5'd1, 5'd2, 13'd0, 32'd20, 32'd22, RDY, RDY, 3'd6);
    wait_result("after_rst", 3'd6, 32'd42, LAT);
    expect_idle("after_rst");

    // An issue presented during DONE is dropped; the same issue one cycle later is taken.
    do_issue("b2b_first", INST_SUB, 5'd1, 5'd2, 13'd0, 32'd50, 32'd8, RDY, RDY, 3'd4);
    wait_result("b2b_first", 3'd4, 32'd42, LAT);
    CDB_inst_fu = 4'd0; CDB_inst_inst = mk(INST_ADD, 5'd1, 5'd2, 13'd0);
    CDB_inst_RBindex = 3'd2; vj = 32'd1; vk = 32'd1; qj = RDY; qk = RDY;
    @(posedge clk); @(negedge clk);
    check("b2b_drop_at_done", 256'(busy), 256'(1'b0));
    @(posedge clk); @(negedge clk);
    check("b2b_take_after", 256'(busy), 256'(1'b1));
    CDB_inst_fu = NO_FU;
    wait_result("b2b_second", 3'd2, 32'd2, LAT);
    expect_idle("b2b_second");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
